fetch_control: RTL and testbench

- Owns the program counter and sequences a synchronous single-read-port instruction memory.
- Issues one fetch per cycle and tracks the 1-cycle memory read latency.
- Buffers returned instructions in a small FIFO with a valid/ready handshake to decode.
- Handles pipeline stalls through `pcwrite` and backpressure, and handles branch redirects by flushing in-flight and buffered fetches.

---
 rtl/fetch_control.sv | 124 ++++++++++++
 tb/tb_fetch_control.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_control.sv
// fetch_control
//   Owns the program counter and drives a synchronous, single-read-port
//   instruction memory with one-cycle read latency. One fetch can be issued
//   per cycle. Returned words are queued in a small FIFO and handed to decode
//   over a valid/ready handshake. A branch redirect flushes the in-flight word
//   and everything buffered, then restarts fetch from the target.
//
// Ports
//   clk             system clock, all state on posedge
//   rst             synchronous reset, active low (0 = reset)
//   pcwrite         fetch enable; 0 freezes PC and issue
//   redirect_valid  branch/jump taken this cycle
//   redirect_pc     redirect target
//   imem_addr       instruction memory address (the PC register)
//   imem_rdata      memory data, valid the cycle after the address was sampled
//   out_valid       buffer head holds a valid instruction
//   out_ready       decode accepts the head this cycle
//   out_ir          head instruction (0 when empty)
//   out_pc          fetch address of the head instruction (0 when empty)
//   busy            a fetch is in flight or the buffer is non-empty
module fetch_control #(
  parameter int                  PC_WIDTH   = 16,
  parameter int                  INST_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = 16'h0000,
  parameter int                  DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pcwrite,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] out_ir,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic                  busy
);

  localparam int AW = $clog2(DEPTH);      // FIFO pointer width
  localparam int CW = $clog2(DEPTH + 1);  // occupancy counter width
  localparam int RW = CW + 1;             // headroom for count + inflight

  logic [PC_WIDTH-1:0]   pc_reg;
  logic                  inflight_reg;
  logic [PC_WIDTH-1:0]   inflight_pc_reg;
  logic [CW-1:0]         count_reg;
  logic [CW-1:0]         count_next;
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;

  logic [INST_WIDTH-1:0] ir_mem [DEPTH];
  logic [PC_WIDTH-1:0]   pc_mem [DEPTH];

  logic                  not_empty;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [RW-1:0]         reserved;

  assign not_empty = (count_reg != '0);

  // A redirect hides the head so decode never consumes a wrong-path word.
  assign out_valid = not_empty & ~redirect_valid;
  assign pop       = out_valid & out_ready;

  // The returning word is dropped when a redirect lands on the same edge.
  assign push      = inflight_reg & ~redirect_valid;

  // Slots already committed: buffered words plus the one still in the
  // memory pipeline, minus the one leaving this cycle. Issuing only while
  // this is below DEPTH guarantees the FIFO can never overflow.
  assign reserved  = RW'(count_reg) + RW'(inflight_reg) - RW'(pop);
  assign issue     = rst & pcwrite & ~redirect_valid & (reserved < RW'(DEPTH));

  assign count_next = count_reg + CW'(push) - CW'(pop);

  assign imem_addr = pc_reg;
  assign out_ir    = not_empty ? ir_mem[rd_ptr_reg] : '0;
  assign out_pc    = not_empty ? pc_mem[rd_ptr_reg] : '0;
  assign busy      = inflight_reg | not_empty;

  // PC, memory-pipeline tracking and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg          <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else if (redirect_valid) begin
      pc_reg          <= redirect_pc;
      inflight_reg    <= 1'b0;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        pc_reg          <= pc_reg + PC_WIDTH'(1);
        inflight_pc_reg <= pc_reg;
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
    end
  end

  // FIFO payload storage. Contents need no reset: the head is masked to
  // zero whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      ir_mem[wr_ptr_reg] <= imem_rdata;
      pc_mem[wr_ptr_reg] <= inflight_pc_reg;
    end
  end

endmodule

// File: tb/tb_fetch_control.sv
module tb_fetch_control;

  logic        clk;
  logic        rst;
  logic        pcwrite;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ir;
  logic [15:0] out_pc;
  logic        busy;

  int checks;
  int failures;

  fetch_control #(
    .PC_WIDTH  (16),
    .INST_WIDTH(16),
    .RESET_PC  (16'h0000),
    .DEPTH     (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pcwrite       (pcwrite),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_ir        (out_ir),
    .out_pc        (out_pc),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Synchronous memory: word at address a is 16'hA000 + a.
  always @(posedge clk) begin
    imem_rdata <= 16'hA000 + imem_addr;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_head(input string tag, input logic [15:0] pc);
    logic [15:0] ir;
    ir = 16'hA000 + pc;
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_pc"}, 32'(out_pc), 32'(pc));
    check_eq({tag, "_ir"}, 32'(out_ir), 32'(ir));
  endtask

  // One line per delivered instruction, plus a bound on buffer occupancy.
  always @(negedge clk) begin
    if (out_valid && out_ready)
      $display("txn pc=%h ir=%h", out_pc, out_ir);
    if (rst)
      check_eq("count_le_depth", 32'(dut.count_reg <= 2), 32'd1);
  end

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    pcwrite = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    checks = 0;
    failures = 0;

    // 1. Reset then streaming
    tick(); tick();
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_addr", 32'(imem_addr), 32'h0000);
    check_eq("rst_pc", 32'(out_pc), 32'h0000);
    check_eq("rst_ir", 32'(out_ir), 32'h0000);
    rst = 1'b1;
    tick();
    check_eq("first_valid", 32'(out_valid), 32'd0);
    check_eq("first_busy", 32'(busy), 32'd1);
    check_eq("first_addr", 32'(imem_addr), 32'h0001);
    tick();
    expect_head("stream0", 16'h0000);
    for (int k = 1; k <= 4; k++) begin
      tick();
      expect_head("stream", 16'(k));
    end

    // 2. Backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_addr", 32'(imem_addr), 32'h0006);
      expect_head("bp_hold", 16'h0004);
    end
    check_eq("bp_count", 32'(dut.count_reg), 32'd2);
    out_ready = 1'b1;
    for (int k = 5; k <= 8; k++) begin
      tick();
      expect_head("bp_rel", 16'(k));
    end

    // 3. Stall
    pcwrite = 1'b0;
    tick();
    expect_head("stall_drain", 16'h0009);
    check_eq("stall_addr0", 32'(imem_addr), 32'h000A);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("stall_valid", 32'(out_valid), 32'd0);
      check_eq("stall_busy", 32'(busy), 32'd0);
      check_eq("stall_addr", 32'(imem_addr), 32'h000A);
    end
    pcwrite = 1'b1;
    tick();
    check_eq("resume_valid", 32'(out_valid), 32'd0);
    check_eq("resume_addr", 32'(imem_addr), 32'h000B);
    tick();
    expect_head("resume0", 16'h000A);
    tick();
    expect_head("resume1", 16'h000B);

    // 4. Redirect while streaming
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    #1;
    check_eq("redir_mask", 32'(out_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    check_eq("redir_valid0", 32'(out_valid), 32'd0);
    check_eq("redir_busy", 32'(busy), 32'd0);
    check_eq("redir_addr", 32'(imem_addr), 32'h0040);
    tick();
    check_eq("redir_valid1", 32'(out_valid), 32'd0);
    check_eq("redir_addr1", 32'(imem_addr), 32'h0041);
    tick();
    expect_head("redir_t0", 16'h0040);
    tick();
    expect_head("redir_t1", 16'h0041);

    // 5. Wrap, then reset coinciding with a redirect
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    tick();
    redirect_valid = 1'b0;
    check_eq("wrap_addr0", 32'(imem_addr), 32'hFFFE);
    tick();
    check_eq("wrap_valid", 32'(out_valid), 32'd0);
    check_eq("wrap_addr1", 32'(imem_addr), 32'hFFFF);
    tick();
    expect_head("wrap_fffe", 16'hFFFE);
    check_eq("wrap_addr2", 32'(imem_addr), 32'h0000);
    tick();
    expect_head("wrap_ffff", 16'hFFFF);
    tick();
    expect_head("wrap_0000", 16'h0000);
    rst = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 16'h1234;
    tick();
    redirect_valid = 1'b0;
    check_eq("rstredir_addr", 32'(imem_addr), 32'h0000);
    check_eq("rstredir_valid", 32'(out_valid), 32'd0);
    check_eq("rstredir_busy", 32'(busy), 32'd0);
    check_eq("rstredir_pc", 32'(out_pc), 32'h0000);
    check_eq("rstredir_ir", 32'(out_ir), 32'h0000);
    rst = 1'b1;
    tick();
    tick();
    expect_head("restart0", 16'h0000);

    // 6. Redirect with a full buffer, decode stalled and fetch disabled
    out_ready = 1'b0;
    tick();
    check_eq("full_count", 32'(dut.count_reg), 32'd2);
    check_eq("full_addr", 32'(imem_addr), 32'h0002);
    pcwrite = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0080;
    #1;
    check_eq("full_redir_mask", 32'(out_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    check_eq("flush_valid", 32'(out_valid), 32'd0);
    check_eq("flush_busy", 32'(busy), 32'd0);
    check_eq("flush_count", 32'(dut.count_reg), 32'd0);
    check_eq("flush_addr", 32'(imem_addr), 32'h0080);
    tick();
    check_eq("flush_hold_addr", 32'(imem_addr), 32'h0080);
    check_eq("flush_hold_busy", 32'(busy), 32'd0);
    pcwrite = 1'b1;
    out_ready = 1'b1;
    tick();
    check_eq("tgt_valid", 32'(out_valid), 32'd0);
    check_eq("tgt_addr", 32'(imem_addr), 32'h0081);
    tick();
    expect_head("tgt0", 16'h0080);
    tick();
    expect_head("tgt1", 16'h0081);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
